// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared types and constants for the 5-stage MIPS hazard logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   localparam logic [1:0] STATS_SEL_STALL   = 2'd0;
   localparam logic [1:0] STATS_SEL_FLUSH   = 2'd1;
   localparam logic [1:0] STATS_SEL_LOADUSE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hazard_stats.sv
// ============================================================================
// Module  : hazard_stats
// Brief   : Wrapping 32-bit event counters for stalls, flushes and load-use
//           hazards, with a selectable read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stats
   import mips_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_evt,
   input  logic        flush_evt,
   input  logic        loaduse_evt,
   input  logic [1:0]  stats_sel,
   output logic [31:0] stats_data
);

   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_count;
   logic [31:0] r_loaduse_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cycles  <= 32'd0;
         r_flush_count   <= 32'd0;
         r_loaduse_count <= 32'd0;
      end else begin
         if (stall_evt)   r_stall_cycles  <= r_stall_cycles + 32'd1;
         if (flush_evt)   r_flush_count   <= r_flush_count + 32'd1;
         if (loaduse_evt) r_loaduse_count <= r_loaduse_count + 32'd1;
      end
   end

   always_comb begin
      stats_data = 32'd0;
      case (stats_sel)
         STATS_SEL_STALL:   stats_data = r_stall_cycles;
         STATS_SEL_FLUSH:   stats_data = r_flush_count;
         STATS_SEL_LOADUSE: stats_data = r_loaduse_count;
         default:           stats_data = 32'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module  : hazard_unit
// Brief   : ID-stage hazard detection: load-use, branch operands, mult/div
//           occupancy and taken-branch redirect. Optional HAZARD_STATS_EN
//           adds event counters and a stats read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit
   import mips_pkg::*;
#(
   parameter int MULDIV_LAT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  reg_idx_t    ifid_rs,
   input  reg_idx_t    ifid_rt,
   input  logic        ifid_uses_rt,
   input  logic        ifid_branch,
   input  logic        idex_memread,
   input  logic        idex_regwrite,
   input  reg_idx_t    idex_wreg,
   input  logic        exmem_memread,
   input  reg_idx_t    exmem_wreg,
   input  logic        muldiv_start,
   input  logic        branch_taken,
`ifdef HAZARD_STATS_EN
   input  logic [1:0]  stats_sel,
   output logic [31:0] stats_data,
`endif
   output logic        stall_pc,
   output logic        stall_ifid,
   output logic        bubble_idex,
   output logic        stall_idex,
   output logic        bubble_exmem,
   output logic        flush_ifid,
   output logic        muldiv_busy
);

   localparam logic [3:0] c_cnt_load = 4'(MULDIV_LAT - 1);

   hz_state_t  r_state, w_state_nxt;
   logic [3:0] r_cnt,   w_cnt_nxt;

   logic w_m_ex;
   logic w_m_mem;
   logic w_load_use;
   logic w_br_stall;

   assign w_m_ex  = (idex_wreg != REG_ZERO) &&
                    ((idex_wreg == ifid_rs) || (ifid_uses_rt && (idex_wreg == ifid_rt)));
   assign w_m_mem = (exmem_wreg != REG_ZERO) &&
                    ((exmem_wreg == ifid_rs) || (ifid_uses_rt && (exmem_wreg == ifid_rt)));

   assign w_load_use = idex_memread && w_m_ex;
   // A load feeding a branch stalls twice: once via the ID/EX term, then via EX/MEM.
   assign w_br_stall = ifid_branch &&
                       ((idex_regwrite && w_m_ex) || (exmem_memread && w_m_mem));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         RUN: begin
            if (muldiv_start && !branch_taken) begin
               w_state_nxt = MD_BUSY;
               w_cnt_nxt   = c_cnt_load;
            end
         end
         MD_BUSY: begin
            if (r_cnt == 4'd1) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = 4'd0;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   always_comb begin
      stall_pc     = 1'b0;
      stall_ifid   = 1'b0;
      bubble_idex  = 1'b0;
      stall_idex   = 1'b0;
      bubble_exmem = 1'b0;
      flush_ifid   = 1'b0;
      muldiv_busy  = 1'b0;
      if (!reset) begin
         muldiv_busy = (r_state == MD_BUSY);
         if (branch_taken) begin
            flush_ifid = 1'b1;
         end else if (r_state == MD_BUSY) begin
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
         end else if (w_br_stall || w_load_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
         end
      end
   end

   a_no_start_on_redirect : assert property (
      @(posedge clock) disable iff (reset) !(muldiv_start && branch_taken));

`ifdef HAZARD_STATS_EN
   logic w_loaduse_evt;
   assign w_loaduse_evt = w_load_use && bubble_idex;

   hazard_stats u_stats (
      .clock       (clock),
      .reset       (reset),
      .stall_evt   (stall_pc),
      .flush_evt   (flush_ifid),
      .loaduse_evt (w_loaduse_evt),
      .stats_sel   (stats_sel),
      .stats_data  (stats_data)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ============================================================================
// Module  : tb_hazard_unit
// Brief   : Directed self-checking bench for hazard_unit (MULDIV_LAT = 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_unit;
   import mips_pkg::*;

   logic     clock = 1'b0;
   logic     reset;
   reg_idx_t ifid_rs, ifid_rt, idex_wreg, exmem_wreg;
   logic     ifid_uses_rt, ifid_branch, idex_memread, idex_regwrite;
   logic     exmem_memread, muldiv_start, branch_taken;
   logic     stall_pc, stall_ifid, bubble_idex, stall_idex;
   logic     bubble_exmem, flush_ifid, muldiv_busy;
`ifdef HAZARD_STATS_EN
   logic [1:0]  stats_sel;
   logic [31:0] stats_data;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [6:0] ctl;
   } exp_t;
   exp_t sb[$];

   hazard_unit #(.MULDIV_LAT(4)) dut (
      .clock         (clock),
      .reset         (reset),
      .ifid_rs       (ifid_rs),
      .ifid_rt       (ifid_rt),
      .ifid_uses_rt  (ifid_uses_rt),
      .ifid_branch   (ifid_branch),
      .idex_memread  (idex_memread),
      .idex_regwrite (idex_regwrite),
      .idex_wreg     (idex_wreg),
      .exmem_memread (exmem_memread),
      .exmem_wreg    (exmem_wreg),
      .muldiv_start  (muldiv_start),
      .branch_taken  (branch_taken),
`ifdef HAZARD_STATS_EN
      .stats_sel     (stats_sel),
      .stats_data    (stats_data),
`endif
      .stall_pc      (stall_pc),
      .stall_ifid    (stall_ifid),
      .bubble_idex   (bubble_idex),
      .stall_idex    (stall_idex),
      .bubble_exmem  (bubble_exmem),
      .flush_ifid    (flush_ifid),
      .muldiv_busy   (muldiv_busy)
   );

   always #5 clock = ~clock;

   // Expected vectors are {stall_pc, stall_ifid, bubble_idex, stall_idex,
   // bubble_exmem, flush_ifid, muldiv_busy}.
   localparam logic [6:0] E_NONE  = 7'b0000000;
   localparam logic [6:0] E_STALL = 7'b1110000;
   localparam logic [6:0] E_MD    = 7'b1101101;
   localparam logic [6:0] E_FLUSH = 7'b0000010;

   function automatic logic [6:0] ctl_now();
      return {stall_pc, stall_ifid, bubble_idex, stall_idex,
              bubble_exmem, flush_ifid, muldiv_busy};
   endfunction

   task automatic push_exp(input string tag, input logic [6:0] e);
      exp_t x;
      x.tag = tag;
      x.ctl = e;
      sb.push_back(x);
   endtask

   task automatic check_pop();
      exp_t       x;
      logic [6:0] obs;
      x   = sb.pop_front();
      obs = ctl_now();
      total++;
      assert (obs === x.ctl) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.ctl);
      end
   endtask

   task automatic cycle(input string tag, input logic [6:0] e);
      push_exp(tag, e);
      @(negedge clock);
      check_pop();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_in();
      ifid_rs = 5'd0;  ifid_rt = 5'd0;  ifid_uses_rt = 1'b0; ifid_branch = 1'b0;
      idex_memread = 1'b0; idex_regwrite = 1'b0; idex_wreg = 5'd0;
      exmem_memread = 1'b0; exmem_wreg = 5'd0;
      muldiv_start = 1'b0; branch_taken = 1'b0;
   endtask

   task automatic set_load_use();
      idex_memread = 1'b1; idex_regwrite = 1'b1; idex_wreg = 5'd8; ifid_rs = 5'd8;
   endtask

`ifdef HAZARD_STATS_EN
   task automatic check_stat(input string tag, input logic [1:0] sel, input logic [31:0] e);
      stats_sel = sel;
      #1;
      total++;
      assert (stats_data === e) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, stats_data, e);
      end
   endtask
`endif

   initial begin
      clear_in();
`ifdef HAZARD_STATS_EN
      stats_sel = 2'd0;
`endif
      reset = 1'b1;
      set_load_use();
      branch_taken = 1'b1;
      #2;
      push_exp("reset_forces_zero", E_NONE);
      check_pop();
      @(posedge clock); #1;
      clear_in();
      @(posedge clock); #1;
      reset = 1'b0;

      cycle("idle", E_NONE);

      set_load_use();
      cycle("load_use", E_STALL);
      clear_in(); exmem_memread = 1'b1; exmem_wreg = 5'd8; ifid_rs = 5'd8;
      cycle("load_use_self_clear", E_NONE);

      clear_in(); idex_memread = 1'b1; idex_wreg = 5'd0; ifid_rs = 5'd0;
      cycle("load_use_r0", E_NONE);

      clear_in(); idex_memread = 1'b1; idex_wreg = 5'd8; ifid_rt = 5'd8; ifid_rs = 5'd3;
      cycle("load_use_rt_unused", E_NONE);
      ifid_uses_rt = 1'b1;
      cycle("load_use_rt_used", E_STALL);

      clear_in(); ifid_branch = 1'b1; ifid_rt = 5'd9; ifid_rs = 5'd3; ifid_uses_rt = 1'b1;
      idex_regwrite = 1'b1; idex_wreg = 5'd9;
      cycle("branch_alu", E_STALL);
      idex_regwrite = 1'b0; idex_wreg = 5'd0; exmem_wreg = 5'd9;
      cycle("branch_alu_done", E_NONE);

      exmem_wreg = 5'd0; idex_regwrite = 1'b1; idex_memread = 1'b1; idex_wreg = 5'd9;
      cycle("branch_load_c1", E_STALL);
      idex_regwrite = 1'b0; idex_memread = 1'b0; idex_wreg = 5'd0;
      exmem_memread = 1'b1; exmem_wreg = 5'd9;
      cycle("branch_load_c2", E_STALL);
      exmem_memread = 1'b0; exmem_wreg = 5'd0;
      cycle("branch_load_done", E_NONE);

      clear_in(); set_load_use(); branch_taken = 1'b1;
      cycle("prio_redirect", E_FLUSH);

      clear_in(); muldiv_start = 1'b1;
      cycle("md_start", E_NONE);
      muldiv_start = 1'b1; set_load_use();
      cycle("md_busy1", E_MD);
      clear_in();
      cycle("md_busy2", E_MD);
      cycle("md_busy3", E_MD);
      cycle("md_done", E_NONE);

      muldiv_start = 1'b1;
      cycle("md2_start", E_NONE);
      muldiv_start = 1'b0;
      cycle("md2_busy1", E_MD);
      push_exp("md2_busy2", E_MD);
      check_pop();
      reset = 1'b1;
      #1;
      push_exp("reset_abort", E_NONE);
      check_pop();
      @(posedge clock); #1;
      reset = 1'b0;
      cycle("post_reset1", E_NONE);
      cycle("post_reset2", E_NONE);

`ifdef HAZARD_STATS_EN
      check_stat("stats_rst_stall",   STATS_SEL_STALL,   32'd0);
      check_stat("stats_rst_flush",   STATS_SEL_FLUSH,   32'd0);
      check_stat("stats_rst_loaduse", STATS_SEL_LOADUSE, 32'd0);
`endif

      for (int i = 0; i < 5; i++) begin
         set_load_use();
         cycle("stats_lu", E_STALL);
         clear_in();
         cycle("stats_lu_gap", E_NONE);
      end
      for (int i = 0; i < 2; i++) begin
         branch_taken = 1'b1;
         cycle("stats_flush", E_FLUSH);
         clear_in();
         cycle("stats_flush_gap", E_NONE);
      end

`ifdef HAZARD_STATS_EN
      check_stat("stats_stall",   STATS_SEL_STALL,   32'd5);
      check_stat("stats_flush",   STATS_SEL_FLUSH,   32'd2);
      check_stat("stats_loaduse", STATS_SEL_LOADUSE, 32'd5);
      check_stat("stats_sel3",    2'd3,              32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

- Issue-side companion to the EX-stage forwarding unit.
- Detects hazards that forwarding cannot resolve and converts them into stall, bubble and flush controls for the 5-stage MIPS pipeline:
  - load-use,
  - branch-operand-in-ID,
  - multi-cycle mult/div occupancy,
  - taken-branch redirect.
- Sits beside the ID stage.
- Stall decisions for a cycle are combinational from pipeline-register fields plus a small registered FSM/counter for mult/div.

## Interface
- MULDIV_LAT, 4, cycles a mult/div occupies EX (legal range 2..15).
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ifid_rs  in  5  rs of instruction in IF/ID.
- ifid_rt  in  5  rt of instruction in IF/ID.
- ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, store, branch).
- ifid_branch  in  1  IF/ID holds beq/bne resolved in ID.
- idex_memread  in  1  ID/EX holds a load.
- idex_regwrite  in  1  ID/EX writes a register.
- idex_wreg  in  5  destination of ID/EX (after RegDst mux).
- exmem_memread  in  1  EX/MEM holds a load.
- exmem_wreg  in  5  destination of EX/MEM.
- muldiv_start  in  1  mult/div entering EX this cycle.
- branch_taken  in  1  branch resolved taken (redirect PC).
- stall_pc  out  1  hold PC.
- stall_ifid  out  1  hold IF/ID.
- bubble_idex  out  1  load NOP into ID/EX.
- stall_idex  out  1  hold ID/EX (mult/div wait).
- bubble_exmem  out  1  load NOP into EX/MEM.
- flush_ifid  out  1  replace IF/ID with NOP.
- muldiv_busy  out  1  FSM in MD_BUSY.

## Operation
- Register 0 never causes a hazard; every comparison requires wreg != 0.
- Match terms:
  - m_ex = ID/EX dest equals ifid_rs, or equals ifid_rt when ifid_uses_rt.
  - m_mem = EX/MEM dest equals ifid_rs, or equals ifid_rt when ifid_uses_rt.
- Load-use: idex_memread && m_ex → stall_pc, stall_ifid, bubble_idex for one cycle. The load then advances and the condition self-clears.
- Branch-in-ID (when ifid_branch):
  - idex_regwrite && m_ex → stall one cycle.
  - exmem_memread && m_mem → stall one cycle.
  - Load in ID/EX → two cycles total, via the two terms above on consecutive cycles.
- FSM states: RUN, MD_BUSY.
  - RUN → MD_BUSY on muldiv_start; counter loads MULDIV_LAT-1.
  - In MD_BUSY: counter decrements each cycle; stall_pc, stall_ifid, stall_idex, bubble_exmem asserted.
  - MD_BUSY → RUN when counter == 1, so exactly MULDIV_LAT-1 stall cycles.
- Redirect: branch_taken → flush_ifid for that cycle; stalls are suppressed that cycle.
- Priority: branch_taken > MD_BUSY > branch-in-ID > load-use. The bubble_idex/stall_idex pair is never both 1.
- muldiv_start together with branch_taken is illegal: muldiv_start is ignored and a simulation assertion fires.
- muldiv_start while in MD_BUSY is ignored.

## Timing
- All stall/flush/bubble outputs are combinational from inputs and registered state, valid before the next rising edge.
- State and counter update on the rising edge of clock.
- Reset values:
  - state = RUN, counter = 0, muldiv_busy = 0.
  - While reset is high, every output is forced to 0 regardless of inputs.
- Reset asserted during MD_BUSY aborts immediately (asynchronously). First cycle after reset deasserts is RUN with no stall.
- Hazard-detection latency: 0 cycles (same cycle as detection).
- Mult/div stall begins the cycle after muldiv_start.

## Configuration
- HAZARD_STATS_EN defined: adds three 32-bit wrapping counters plus a read port:
  - stall_cycles: any stall_pc.
  - flush_count: flush_ifid cycles.
  - loaduse_count: load-use events.
  - Read port: stats_sel in 2, stats_data out 32.
  - All counters reset to 0.
- HAZARD_STATS_EN undefined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- Shared package mips_pkg holds:
  - hz_state_t enum (RUN, MD_BUSY),
  - reg_idx_t (5-bit),
  - REG_ZERO constant,
  - stats_sel encodings.
- One sub-module, hazard_stats, holds the counters. It is instantiated only under HAZARD_STATS_EN.

## Test plan
- **Load-use:** idex_memread=1, idex_wreg=8, ifid_rs=8 → stall_pc, stall_ifid, bubble_idex = 1 for one cycle. With idex_wreg=0 → no stall.
- **Branch:** ifid_branch=1, ifid_rt=9, ifid_uses_rt=1, idex_regwrite=1, idex_wreg=9 → one-cycle stall. Repeat with idex_memread=1 → stall on two consecutive cycles.
- **Mult/div:** MULDIV_LAT=4, muldiv_start pulse → muldiv_busy and stall_idex high for exactly 3 cycles, then RUN.
- **Priority:** branch_taken=1 concurrent with load-use match → flush_ifid=1, stall_pc=0.
- **Reset abort:** reset asserted in second MD_BUSY cycle → all outputs 0 immediately; after release no stall. Under HAZARD_STATS_EN, counters read 0.
- **Stats:** with HAZARD_STATS_EN, 5 load-use events and 2 flushes → loaduse_count=5, flush_count=2, stall_cycles=5.
